// File: rtl/snn_neuron_tile.sv
// ---------------------------------------------------------------------------
// snn_neuron_tile
//
// Time-step compute tile: N_LANES synaptic accumulators, N_LANES membrane
// potential registers and the FSM that sequences them. One run clears the
// accumulators, integrates ACC_CYCLES weight words (2-bit weights gated by
// 2-bit spikes) and then commits u_prev + acc into each enabled lane.
//
// Ports:
//   clk      - single clock, rising edge
//   reset    - asynchronous, active-low reset of all state
//   start    - run request, only looked at in IDLE
//   w_read   - weight word for w_addr, lane i at [2i+1:2i]
//   spk_in   - spikes, lane i at [2i+1:2i]
//   u_prev   - previous signed potentials, lane i at [8i+7:8i]
//   lane_en  - per-lane commit enable, used in FIRE
//   w_addr   - 11-bit weight SRAM read address, persists across runs
//   u_final  - registered signed potentials, lane i at [8i+7:8i]
//   busy     - high in CLEAR, ACCUM and FIRE
//   done     - one-cycle pulse after the commit edge
// ---------------------------------------------------------------------------
module snn_neuron_tile #(
   parameter int N_LANES    = 4,
   parameter int ACC_CYCLES = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [2*N_LANES-1:0]   w_read,
   input  logic [2*N_LANES-1:0]   spk_in,
   input  logic [8*N_LANES-1:0]   u_prev,
   input  logic [N_LANES-1:0]     lane_en,
   output logic [10:0]            w_addr,
   output logic [8*N_LANES-1:0]   u_final,
   output logic                   busy,
   output logic                   done
);

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      ACCUM,
      FIRE,
      DONE
   } state_t;

   localparam int CW = (ACC_CYCLES > 1) ? $clog2(ACC_CYCLES) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(ACC_CYCLES - 1);

   state_t        state;
   logic [CW-1:0] acc_cnt;

   // Signed contribution of one lane's two synapses: a spike adds +1 for
   // weight bit 1 and -1 for weight bit 0; no spike contributes nothing.
   function automatic logic signed [2:0] contrib(input logic [1:0] w,
                                                 input logic [1:0] s);
      logic signed [2:0] c;
      c = '0;
      for (int k = 0; k < 2; k++) begin
         if (s[k]) begin
            if (w[k]) c = c + 3'sd1;
            else      c = c - 3'sd1;
         end
      end
      return c;
   endfunction

   // Clamp a 10-bit signed sum into the 8-bit signed range.
   function automatic logic signed [7:0] sat8(input logic signed [9:0] v);
      if (v > 10'sd127)
         return 8'sd127;
      else if (v < -10'sd128)
         return 8'sh80;
      else
         return v[7:0];
   endfunction

   // Sequencing FSM. busy and done are registered from the next-state
   // decision so they come straight off flops and cannot glitch.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         acc_cnt <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  state <= CLEAR;
                  busy  <= 1'b1;
               end else begin
                  busy  <= 1'b0;
               end
            end
            CLEAR: begin
               state   <= ACCUM;
               acc_cnt <= '0;
               busy    <= 1'b1;
               done    <= 1'b0;
            end
            ACCUM: begin
               busy <= 1'b1;
               done <= 1'b0;
               if (acc_cnt == LAST_CNT) begin
                  state   <= FIRE;
                  acc_cnt <= '0;
               end else begin
                  acc_cnt <= acc_cnt + 1'b1;
               end
            end
            FIRE: begin
               state <= DONE;
               busy  <= 1'b0;
               done  <= 1'b1;
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
            default: begin
               state   <= IDLE;
               acc_cnt <= '0;
               busy    <= 1'b0;
               done    <= 1'b0;
            end
         endcase
      end
   end

   // Weight address advances once per ACCUM cycle and is never cleared
   // between runs, so back-to-back runs walk through consecutive words.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         w_addr <= '0;
      else if (state == ACCUM)
         w_addr <= w_addr + 11'd1;
   end

   for (genvar i = 0; i < N_LANES; i++) begin : g_lane
      logic        [1:0] w_lane;
      logic        [1:0] s_lane;
      logic signed [2:0] c_lane;
      logic signed [7:0] acc;
      logic signed [7:0] acc_oen;
      logic signed [7:0] u_lane;
      logic signed [7:0] u_reg;
      logic signed [9:0] acc_sum;
      logic signed [9:0] u_sum;

      assign w_lane  = w_read[2*i +: 2];
      assign s_lane  = spk_in[2*i +: 2];
      assign u_lane  = u_prev[8*i +: 8];
      assign c_lane  = contrib(w_lane, s_lane);
      assign acc_sum = {{2{acc[7]}}, acc} + {{7{c_lane[2]}}, c_lane};

      // The neuron only ever sees the accumulator during FIRE.
      assign acc_oen = (state == FIRE) ? acc : 8'sd0;
      assign u_sum   = {{2{u_lane[7]}}, u_lane} + {{2{acc_oen[7]}}, acc_oen};

      // Accumulator: cleared in CLEAR, saturating integrate in ACCUM,
      // so a run of large contributions pins at the rail rather than wrapping.
      always_ff @(posedge clk or negedge reset) begin
         if (!reset)
            acc <= '0;
         else if (state == CLEAR)
            acc <= '0;
         else if (state == ACCUM)
            acc <= sat8(acc_sum);
      end

      // Neuron register: commit on the edge ending FIRE for enabled lanes,
      // otherwise the previous potential is held.
      always_ff @(posedge clk or negedge reset) begin
         if (!reset)
            u_reg <= '0;
         else if (state == FIRE && lane_en[i])
            u_reg <= sat8(u_sum);
      end

      assign u_final[8*i +: 8] = u_reg;
   end

endmodule

// File: tb/tb_snn_neuron_tile.sv
// ---------------------------------------------------------------------------
// tb_snn_neuron_tile
//
// Directed bench for snn_neuron_tile. One instance uses the default
// ACC_CYCLES=8, a second uses ACC_CYCLES=70 so the accumulator itself can
// reach its rails. Expected values are hand-computed per vector.
// ---------------------------------------------------------------------------
`timescale 1ns/100ps
module tb_snn_neuron_tile;

   logic        clk;
   logic        reset;
   logic        start;
   logic        start70;
   logic [7:0]  w_read;
   logic [7:0]  spk_in;
   logic [31:0] u_prev;
   logic [3:0]  lane_en;
   logic [10:0] w_addr;
   logic [31:0] u_final;
   logic        busy;
   logic        done;
   logic [10:0] w_addr70;
   logic [31:0] u_final70;
   logic        busy70;
   logic        done70;

   int total;
   int bad;
   int done_count;

   snn_neuron_tile #(.N_LANES(4), .ACC_CYCLES(8)) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .w_read  (w_read),
      .spk_in  (spk_in),
      .u_prev  (u_prev),
      .lane_en (lane_en),
      .w_addr  (w_addr),
      .u_final (u_final),
      .busy    (busy),
      .done    (done)
   );

   snn_neuron_tile #(.N_LANES(4), .ACC_CYCLES(70)) dut70 (
      .clk     (clk),
      .reset   (reset),
      .start   (start70),
      .w_read  (w_read),
      .spk_in  (spk_in),
      .u_prev  (u_prev),
      .lane_en (lane_en),
      .w_addr  (w_addr70),
      .u_final (u_final70),
      .busy    (busy70),
      .done    (done70)
   );

   // 100 MHz clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count done pulses of the main instance, sampled on the active edge
   always @(posedge clk) begin
      if (done) done_count++;
   end

   // Single comparison point for the whole bench
   task automatic checkOutput(input string tag, input logic signed [31:0] actual,
                              input logic signed [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
      end
   endtask

   // Drive the data-side inputs for the next run
   task automatic applyStimulus(input logic [7:0] w, input logic [7:0] s,
                                input logic [31:0] u, input logic [3:0] en);
      w_read  = w;
      spk_in  = s;
      u_prev  = u;
      lane_en = en;
   endtask

   // Compare the four lanes of one instance, lanes given 3..0
   task automatic checkLanes(input string tag, input bit sel70,
                             input int e3, input int e2, input int e1, input int e0);
      logic [31:0] uf;
      uf = sel70 ? u_final70 : u_final;
      checkOutput({tag, ".lane0"}, $signed(uf[7:0]),   e0);
      checkOutput({tag, ".lane1"}, $signed(uf[15:8]),  e1);
      checkOutput({tag, ".lane2"}, $signed(uf[23:16]), e2);
      checkOutput({tag, ".lane3"}, $signed(uf[31:24]), e3);
   endtask

   // Issue one start pulse and wait (bounded) for done. With noise set,
   // start toggles while busy and is held high through the DONE cycle.
   // Checks the start-to-done latency and that done is a single-cycle pulse.
   task automatic runOnce(input bit sel70, input bit noise, input int exp_lat);
      int  cycles;
      logic d;
      @(negedge clk);
      if (sel70) start70 = 1'b1; else start = 1'b1;
      @(posedge clk);
      #1;
      if (sel70) start70 = 1'b0; else start = 1'b0;
      cycles = 0;
      d = 1'b0;
      while (!d && cycles < exp_lat + 20) begin
         @(posedge clk);
         #1;
         cycles++;
         d = sel70 ? done70 : done;
         if (noise && !d) start = cycles[0];
      end
      checkOutput("latency", cycles, exp_lat);
      if (noise) start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      checkOutput("done_pulse", sel70 ? done70 : done, 0);
      checkOutput("busy_after", sel70 ? busy70 : busy, 0);
   endtask

   initial begin
      int dc0;
      total      = 0;
      bad        = 0;
      done_count = 0;
      start      = 1'b0;
      start70    = 1'b0;
      applyStimulus(8'h00, 8'h00, 32'h0, 4'h0);

      // Reset state
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst.busy",    busy, 0);
      checkOutput("rst.done",    done, 0);
      checkOutput("rst.w_addr",  w_addr, 0);
      checkOutput("rst.u_final", u_final, 0);
      @(negedge clk);
      reset = 1'b1;

      // All +2 per cycle for 8 cycles, u_prev 0 -> +16 everywhere
      applyStimulus(8'hFF, 8'hFF, 32'h0, 4'hF);
      runOnce(1'b0, 1'b0, 10);
      checkLanes("allpos", 1'b0, 16, 16, 16, 16);
      checkOutput("allpos.w_addr", w_addr, 8);

      // Reset in the middle of ACCUM
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #3;
      reset = 1'b0;
      #1;
      checkOutput("midrst.busy",    busy, 0);
      checkOutput("midrst.w_addr",  w_addr, 0);
      checkOutput("midrst.u_final", u_final, 0);
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("midrst.idle", busy, 0);

      // Clean rerun after the reset
      runOnce(1'b0, 1'b0, 10);
      checkLanes("rerun", 1'b0, 16, 16, 16, 16);
      checkOutput("rerun.w_addr", w_addr, 8);

      // Mixed lanes: -2, 0, 0, +1 per cycle, u_prev 5
      applyStimulus(8'b11_00_10_00, 8'b01_00_11_11, 32'h05050505, 4'hF);
      runOnce(1'b0, 1'b0, 10);
      checkLanes("mixed", 1'b0, 13, 5, 5, -11);
      checkOutput("mixed.w_addr", w_addr, 16);

      // Only lanes 0 and 2 commit: 10 + 16 = 26, lanes 1 and 3 hold
      applyStimulus(8'hFF, 8'hFF, 32'h0A0A0A0A, 4'b0101);
      runOnce(1'b0, 1'b0, 10);
      checkLanes("lane_en", 1'b0, 13, 26, 5, 26);

      // Neuron-side clamping: 120 + 16 and -120 - 16
      applyStimulus(8'hFF, 8'hFF, 32'h78787878, 4'hF);
      runOnce(1'b0, 1'b0, 10);
      checkLanes("usat_pos", 1'b0, 127, 127, 127, 127);
      applyStimulus(8'h00, 8'hFF, 32'h88888888, 4'hF);
      runOnce(1'b0, 1'b0, 10);
      checkLanes("usat_neg", 1'b0, -128, -128, -128, -128);
      checkOutput("usat.w_addr", w_addr, 40);

      // 70 cycles of +2 pins acc at +127; 100 + 127 clamps to +127
      applyStimulus(8'hFF, 8'hFF, 32'h64646464, 4'hF);
      runOnce(1'b1, 1'b0, 72);
      checkLanes("accsat_pos", 1'b1, 127, 127, 127, 127);
      checkOutput("accsat.w_addr", w_addr70, 70);

      // 70 cycles of -2 pins acc at -128; -100 - 128 clamps to -128
      applyStimulus(8'h00, 8'hFF, 32'h9C9C9C9C, 4'hF);
      runOnce(1'b1, 1'b0, 72);
      checkLanes("accsat_neg", 1'b1, -128, -128, -128, -128);

      // 256 runs of 8 words wrap w_addr back to 0; spurious start pulses
      // during busy and a start held through DONE add no runs
      reset = 1'b0;
      #2;
      reset = 1'b1;
      applyStimulus(8'hFF, 8'hFF, 32'h0, 4'hF);
      dc0 = done_count;
      for (int r = 0; r < 255; r++) runOnce(1'b0, 1'b1, 10);
      checkOutput("wrap.pre", w_addr, 2040);
      runOnce(1'b0, 1'b1, 10);
      checkOutput("wrap.w_addr", w_addr, 0);
      repeat (4) @(posedge clk);
      #1;
      checkOutput("wrap.idle", busy, 0);
      checkOutput("wrap.dones", done_count - dc0, 256);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
